// File: rtl/sr_bank_driver.sv
// sr_bank_driver
//   Write-side controller for a bank of WIDTH SR flip-flops. A target word is
//   accepted over a valid/ready handshake. The driver converts it into per-bit
//   S/R excitation against the bank's current q. It drives that excitation for
//   SETTLE cycles and then releases it for one cycle. Finally it compares the
//   bank feedback against the target and reports done (and err on failure).
//   S and R are never both high on the same bit.
//
//   Optional feature macro: SR_RETRY_EN
//     When defined, the first failed check triggers one re-apply against the
//     freshly sampled bank state. A second failure reports err.
//     When undefined, the first failed check reports err immediately.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   tgt_valid  target word offered
//   tgt_data   requested next bank state (WIDTH)
//   tgt_ready  driver can accept a target (high only in IDLE)
//   q_in       q feedback from the bank, synchronous to clk (WIDTH)
//   s_out      registered set lines to the bank (WIDTH)
//   r_out      registered reset lines to the bank (WIDTH)
//   busy       high in any state other than IDLE
//   done       one-cycle pulse when a request completes
//   err        one-cycle pulse together with done when the bank missed the target
module sr_bank_driver #(
  parameter int WIDTH  = 8,
  parameter int SETTLE = 2   // legal range 1..15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tgt_valid,
  input  logic [WIDTH-1:0] tgt_data,
  output logic             tgt_ready,
  input  logic [WIDTH-1:0] q_in,
  output logic [WIDTH-1:0] s_out,
  output logic [WIDTH-1:0] r_out,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    APPLY   = 2'd1,
    RELEASE = 2'd2,
    CHECK   = 2'd3
  } state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] s_reg, s_next;
  logic [WIDTH-1:0] r_reg, r_next;
  logic [WIDTH-1:0] tgt_q_reg, tgt_q_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             done_reg, done_next;
  logic             err_reg, err_next;
`ifdef SR_RETRY_EN
  logic             retry_reg, retry_next;
`endif

  // Excitation is always computed against the live q_in (the current bank
  // state sampled at this edge). The target is the incoming word in IDLE and
  // the latched target otherwise, which covers the retry re-apply.
  logic [WIDTH-1:0] nxt_sel;
  logic [WIDTH-1:0] exc_s;
  logic [WIDTH-1:0] exc_r;

  assign nxt_sel = (state_reg == IDLE) ? tgt_data : tgt_q_reg;

  // S only where 0->1 and R only where 1->0, so S&R is zero by construction.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_exc
      assign exc_s[gi] = ~q_in[gi] &  nxt_sel[gi];
      assign exc_r[gi] =  q_in[gi] & ~nxt_sel[gi];
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    s_next     = s_reg;
    r_next     = r_reg;
    tgt_q_next = tgt_q_reg;
    cnt_next   = cnt_reg;
    done_next  = 1'b0;
    err_next   = 1'b0;
`ifdef SR_RETRY_EN
    retry_next = retry_reg;
`endif

    case (state_reg)
      IDLE: begin
        if (tgt_valid) begin
          tgt_q_next = tgt_data;
          if (tgt_data == q_in) begin
            // Nothing to drive; go straight to verification.
            s_next     = '0;
            r_next     = '0;
            state_next = CHECK;
          end else begin
            s_next     = exc_s;
            r_next     = exc_r;
            cnt_next   = CNT_W'(SETTLE - 1);
            state_next = APPLY;
          end
        end
      end

      APPLY: begin
        // The counter starts at SETTLE-1. Leaving on zero keeps S/R active
        // for exactly SETTLE cycles.
        if (cnt_reg == '0) begin
          s_next     = '0;
          r_next     = '0;
          state_next = RELEASE;
        end else begin
          cnt_next = cnt_reg - CNT_W'(1);
        end
      end

      RELEASE: begin
        state_next = CHECK;
      end

      CHECK: begin
        if (q_in == tgt_q_reg) begin
          done_next  = 1'b1;
          state_next = IDLE;
`ifdef SR_RETRY_EN
          retry_next = 1'b0;
`endif
        end else begin
`ifdef SR_RETRY_EN
          if (!retry_reg) begin
            retry_next = 1'b1;
            s_next     = exc_s;
            r_next     = exc_r;
            cnt_next   = CNT_W'(SETTLE - 1);
            state_next = APPLY;
          end else begin
            done_next  = 1'b1;
            err_next   = 1'b1;
            retry_next = 1'b0;
            state_next = IDLE;
          end
`else
          done_next  = 1'b1;
          err_next   = 1'b1;
          state_next = IDLE;
`endif
        end
      end

      default: begin
        s_next     = '0;
        r_next     = '0;
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      s_reg     <= '0;
      r_reg     <= '0;
      tgt_q_reg <= '0;
      cnt_reg   <= '0;
      done_reg  <= 1'b0;
      err_reg   <= 1'b0;
`ifdef SR_RETRY_EN
      retry_reg <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      s_reg     <= s_next;
      r_reg     <= r_next;
      tgt_q_reg <= tgt_q_next;
      cnt_reg   <= cnt_next;
      done_reg  <= done_next;
      err_reg   <= err_next;
`ifdef SR_RETRY_EN
      retry_reg <= retry_next;
`endif
    end
  end

  assign s_out     = s_reg;
  assign r_out     = r_reg;
  assign tgt_ready = (state_reg == IDLE);
  assign busy      = (state_reg != IDLE);
  assign done      = done_reg;
  assign err       = err_reg;

endmodule

// File: doc/sr_bank_driver.md
Name: sr_bank_driver

Overview:
- Write-side controller for a bank of WIDTH SR flip-flops. It turns a requested target word into legal per-bit S/R excitation, drives it for a programmable hold time, releases, then checks the bank's q feedback against the target.
- Sits between a valid/ready requester and the S/R inputs of the flip-flop bank.
- Never emits the forbidden S=R=1 combination.

Parameters:
- WIDTH, 8, number of SR flip-flops driven.
- SETTLE, 2, cycles S/R held active per apply (legal range 1..15).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset.
- tgt_valid  input  1  target word offered.
- tgt_data  input  WIDTH  requested next bank state.
- tgt_ready  output  1  driver can accept a target.
- q_in  input  WIDTH  q outputs fed back from the bank.
- s_out  output  WIDTH  set lines to the bank (registered).
- r_out  output  WIDTH  reset lines to the bank (registered).
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle pulse when a request completes.
- err  output  1  one-cycle pulse with done if the bank failed to reach the target.

Behaviour:
- Reset (rst=0, asynchronous): s_out=0, r_out=0, done=0, err=0, busy=0, tgt_ready=1, state=IDLE, settle counter=0, retry flag=0.
  - Reset mid-operation drops all S/R lines to 0 immediately, with no clock edge required.
- States: IDLE, APPLY, RELEASE, CHECK.
- IDLE: tgt_ready=1.
  - On a clock edge with tgt_valid=1, latch tgt_data into tgt_q and sample q_in into cur_q.
  - Compute per-bit excitation:
    - cur 0 -> nxt 1: S=1, R=0.
    - cur 1 -> nxt 0: S=0, R=1.
    - cur = nxt: S=0, R=0 (hold).
  - If tgt_data == q_in: go directly to CHECK with s_out/r_out=0.
  - Otherwise: register the excitation into s_out/r_out, load the counter with SETTLE-1, go to APPLY.
- APPLY: s_out/r_out held constant; counter decrements each cycle. When the counter is 0, clear s_out/r_out to 0 and go to RELEASE.
  - Result: S/R are active for exactly SETTLE cycles.
- RELEASE: S/R=0 for one cycle, then go to CHECK.
- CHECK: compare q_in with tgt_q.
  - Match: pulse done=1, err=0 in the next cycle and return to IDLE.
  - Mismatch: see Optional Feature.
- Handshake:
  - tgt_ready=0 whenever busy=1; tgt_valid is ignored while busy.
  - Requester must hold tgt_valid/tgt_data until an accept edge (tgt_valid & tgt_ready).
  - tgt_ready is high again in the same cycle done pulses, so back-to-back requests are accepted at that edge.
- Latency, with accept edge T and a changing target: S/R active for cycles T+1..T+SETTLE, RELEASE at T+SETTLE+1, CHECK at T+SETTLE+2, done at T+SETTLE+3.
- Latency, no-change target: CHECK at T+1, done at T+2.
- Invariant: (s_out & r_out) == 0 in every cycle, including reset and mid-transition.
- q_in is treated as synchronous to clk; no synchronizer is inside this block.

Optional Feature:
- Macro: SR_RETRY_EN.
- Defined:
  - On the first mismatch in CHECK, set the retry flag, resample q_in into cur_q, recompute the excitation against tgt_q and re-enter APPLY for another SETTLE cycles.
  - A second mismatch pulses done=1 and err=1.
  - The retry flag clears on return to IDLE.
- Not defined: the first mismatch pulses done=1 and err=1 immediately; there is no retry logic and no retry flag register.

Test Plan:
- Bench: WIDTH=8, SETTLE=2, with a behavioural 8-bit SR bank model that updates q on the clock when S or R is set.
- Reset: hold rst=0 while tgt_valid=1 -> s_out=r_out=0, tgt_ready=1, busy=0, done=0; after rst=1, the first accept occurs only on the next edge.
- Basic write: bank=8'h00, target 8'hA5 -> s_out=8'hA5, r_out=8'h00 for exactly 2 cycles, then 0; done pulses at T+5 with err=0; bank reads 8'hA5.
- Mixed set/clear: bank=8'hA5, target 8'h3C -> s_out=8'h18, r_out=8'h81 for 2 cycles; done at T+5, err=0; (s_out&r_out)==0 every cycle.
- No-change: bank=8'h3C, target 8'h3C -> s_out/r_out stay 0; done at T+2, err=0.
- Stuck bit: model forces bit 0 stuck at 0, target 8'h01.
  - Without SR_RETRY_EN: done&err at T+5.
  - With SR_RETRY_EN: a second 2-cycle apply with s_out=8'h01, then done&err at T+9.
- Busy and reset mid-op:
  - tgt_valid held high with a new word during APPLY -> not accepted until the done cycle; accepted back-to-back there.
  - rst=0 in APPLY -> s_out/r_out go to 0 asynchronously; done never pulses.
